wb_sched: RTL and testbench

- Shares the single register-file write port between two sources:
  - the in-order pipeline writeback stage, which writes PC+4 or ALU results;
  - a variable-latency load-return channel.
- Load returns are buffered in a small FIFO.
- Each cycle one source is granted. WAW ordering on the same rd is enforced, and loads cannot be starved.
- Sits between the WB stage, the LSU and the regfile write port, and drives the pipeline stall when writeback is blocked.

---
 rtl/wb_sched.sv | 128 ++++++++++++
 tb/tb_wb_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sched.sv
// Register-file write-port scheduler: arbitrates between the in-order WB stage
// and a small load-return FIFO, with WAW ordering and a load starvation bound.
module wb_sched #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pipe_wb_vld_i,
  input  logic [1:0]  pipe_wb_sel_i,
  input  logic [4:0]  pipe_rd_addr_i,
  input  logic [31:0] pipe_alu_data_i,
  input  logic [31:0] pipe_pc_four_i,
  output logic        pipe_stall_o,
  input  logic        ld_vld_i,
  input  logic [4:0]  ld_rd_addr_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_rdy_o,
  output logic        rf_wren_o,
  output logic [4:0]  rf_rd_addr_o,
  output logic [31:0] rf_wb_data_o,
  output logic        ld_pending_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [4:0]       rdMem_q   [DEPTH];
  logic [31:0]      dataMem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             rfWren_q, rfWren_d;
  logic [4:0]       rfAddr_q, rfAddr_d;
  logic [31:0]      rfData_q, rfData_d;

  logic pipeReq, notEmpty, full, wawHit, ldGnt, pipeGnt, push;

  assign pipeReq  = pipe_wb_vld_i & ~pipe_wb_sel_i[1];
  assign notEmpty = (count_q != '0);
  assign full     = (count_q == FULL_CNT);
  assign push     = ld_vld_i & ~full;

  // An older buffered load to the same rd must reach the regfile first.
  always_comb begin
    wawHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rdMem_q[i] == pipe_rd_addr_i)) wawHit = 1'b1;
    end
  end

  assign ldGnt   = notEmpty & (~pipeReq | full | (starve_q == STARVE_LIM) | wawHit);
  assign pipeGnt = pipeReq & ~ldGnt;

  always_comb begin
    count_d = count_q;
    if (push && !ldGnt)      count_d = count_q + CW'(1);
    else if (!push && ldGnt) count_d = count_q - CW'(1);
  end

  always_comb begin
    starve_d = starve_q;
    if (!notEmpty || ldGnt)                   starve_d = '0;
    else if (pipeGnt && starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
  end

  // Writes to x0 still consume their source but never assert the enable.
  always_comb begin
    rfWren_d = 1'b0;
    rfAddr_d = rfAddr_q;
    rfData_d = rfData_q;
    if (ldGnt) begin
      rfWren_d = (rdMem_q[head_q] != 5'd0);
      rfAddr_d = rdMem_q[head_q];
      rfData_d = dataMem_q[head_q];
    end else if (pipeGnt) begin
      rfWren_d = (pipe_rd_addr_i != 5'd0);
      rfAddr_d = pipe_rd_addr_i;
      rfData_d = pipe_wb_sel_i[0] ? pipe_alu_data_i : pipe_pc_four_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      starve_q <= '0;
      rfWren_q <= 1'b0;
      rfAddr_q <= '0;
      rfData_q <= '0;
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
      rfWren_q <= rfWren_d;
      rfAddr_q <= rfAddr_d;
      rfData_q <= rfData_d;
      if (push) begin
        tail_q        <= tail_q + AW'(1);
        vld_q[tail_q] <= 1'b1;
      end
      if (ldGnt) begin
        head_q        <= head_q + AW'(1);
        vld_q[head_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      rdMem_q[tail_q]   <= ld_rd_addr_i;
      dataMem_q[tail_q] <= ld_data_i;
    end
  end

  assign pipe_stall_o = pipeReq & ldGnt;
  assign ld_rdy_o     = ~full;
  assign ld_pending_o = notEmpty;
  assign rf_wren_o    = rfWren_q;
  assign rf_rd_addr_o = rfAddr_q;
  assign rf_wb_data_o = rfData_q;

endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: expected regfile writes are queued as stimulus is
// driven and retired in order by a monitor watching the registered write port.
module tb_wb_sched;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        pipeWbVld;
  logic [1:0]  pipeWbSel;
  logic [4:0]  pipeRdAddr;
  logic [31:0] pipeAluData;
  logic [31:0] pipePcFour;
  logic        pipeStall;
  logic        ldVld;
  logic [4:0]  ldRdAddr;
  logic [31:0] ldData;
  logic        ldRdy;
  logic        rfWren;
  logic [4:0]  rfRdAddr;
  logic [31:0] rfWbData;
  logic        ldPending;

  int checks = 0;
  int failures = 0;
  wr_t expQ[$];
  logic [31:0] shadowRf [32];

  wb_sched dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .pipe_wb_vld_i  (pipeWbVld),
    .pipe_wb_sel_i  (pipeWbSel),
    .pipe_rd_addr_i (pipeRdAddr),
    .pipe_alu_data_i(pipeAluData),
    .pipe_pc_four_i (pipePcFour),
    .pipe_stall_o   (pipeStall),
    .ld_vld_i       (ldVld),
    .ld_rd_addr_i   (ldRdAddr),
    .ld_data_i      (ldData),
    .ld_rdy_o       (ldRdy),
    .rf_wren_o      (rfWren),
    .rf_rd_addr_o   (rfRdAddr),
    .rf_wb_data_o   (rfWbData),
    .ld_pending_o   (ldPending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [1:0] ps, input logic [4:0] prd,
                               input logic [31:0] palu, input logic [31:0] ppc,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    pipeWbVld   = pv;
    pipeWbSel   = ps;
    pipeRdAddr  = prd;
    pipeAluData = palu;
    pipePcFour  = ppc;
    ldVld       = lv;
    ldRdAddr    = lrd;
    ldData      = ldat;
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    expQ.push_back(w);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Every write seen on the port must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstN && rfWren) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWrite", 32'(rfWren), 32'd0);
      end else begin
        wr_t w;
        w = expQ.pop_front();
        checkOutput("wrAddr", 32'(rfRdAddr), 32'(w.addr));
        checkOutput("wrData", rfWbData, w.data);
        shadowRf[rfRdAddr] = rfWbData;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] pcVal;
    for (int i = 0; i < 32; i++) shadowRf[i] = '0;
    rstN = 1'b0;
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("rstWren",    32'(rfWren),    32'd0);
    checkOutput("rstAddr",    32'(rfRdAddr),  32'd0);
    checkOutput("rstData",    rfWbData,       32'd0);
    checkOutput("rstStall",   32'(pipeStall), 32'd0);
    checkOutput("rstLdRdy",   32'(ldRdy),     32'd1);
    checkOutput("rstPending", 32'(ldPending), 32'd0);
    @(posedge clk);
    #1 rstN = 1'b1;

    $display("[TB] test 1: pipe ALU write");
    applyStimulus(1, 2'b01, 5, 32'h1234_5678, 0, 0, 0, 0);
    expectWrite(5, 32'h1234_5678);
    @(negedge clk);
    checkOutput("t1Stall", 32'(pipeStall), 32'd0);
    nextCycle();
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1Wren", 32'(rfWren), 32'd1);

    $display("[TB] test 2: load only, then load to x0");
    nextCycle();
    applyStimulus(0, 2'b00, 0, 0, 0, 1, 7, 32'hDEAD_BEEF);
    expectWrite(7, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("t2LdRdy", 32'(ldRdy), 32'd1);
    nextCycle();
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t2Pending", 32'(ldPending), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("t2Empty", 32'(ldPending), 32'd0);
    checkOutput("t2Wren",  32'(rfWren),    32'd1);
    nextCycle();
    applyStimulus(0, 2'b00, 0, 0, 0, 1, 0, 32'h0000_CAFE);
    nextCycle();
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t2x0Pending", 32'(ldPending), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("t2x0Empty", 32'(ldPending), 32'd0);
    checkOutput("t2x0Wren",  32'(rfWren),    32'd0);

    $display("[TB] test 3: starvation bound");
    pcVal = 32'h100;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      applyStimulus(1, 2'b00, 3, 0, pcVal, (i == 0), 9, 32'h99);
      if (i == 4) expectWrite(9, 32'h99);
      else        expectWrite(3, pcVal);
      @(negedge clk);
      checkOutput($sformatf("t3Stall%0d", i), 32'(pipeStall), 32'(i == 4));
      if (i != 4) pcVal = pcVal + 32'd4;
    end
    nextCycle();
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (2) nextCycle();

    $display("[TB] test 4: WAW ordering");
    applyStimulus(0, 2'b00, 0, 0, 0, 1, 4, 32'h44);
    @(negedge clk);
    checkOutput("t4Stall0", 32'(pipeStall), 32'd0);
    nextCycle();
    applyStimulus(1, 2'b01, 4, 32'h11, 0, 0, 0, 0);
    expectWrite(4, 32'h44);
    @(negedge clk);
    checkOutput("t4Stall1", 32'(pipeStall), 32'd1);
    nextCycle();
    expectWrite(4, 32'h11);
    @(negedge clk);
    checkOutput("t4Stall2", 32'(pipeStall), 32'd0);
    nextCycle();
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t4FinalRd4", shadowRf[4], 32'h11);

    $display("[TB] test 5: FIFO full and backpressure");
    nextCycle();
    applyStimulus(1, 2'b01, 20, 32'h200, 0, 1, 10, 32'hA0);
    expectWrite(20, 32'h200);
    @(negedge clk);
    checkOutput("t5LdRdy0", 32'(ldRdy), 32'd1);
    nextCycle();
    applyStimulus(1, 2'b01, 20, 32'h201, 0, 1, 11, 32'hA1);
    expectWrite(20, 32'h201);
    @(negedge clk);
    checkOutput("t5Stall1", 32'(pipeStall), 32'd0);
    checkOutput("t5LdRdy1", 32'(ldRdy), 32'd1);
    nextCycle();
    applyStimulus(1, 2'b01, 20, 32'h202, 0, 1, 12, 32'hA2);
    expectWrite(10, 32'hA0);
    @(negedge clk);
    checkOutput("t5LdRdyFull", 32'(ldRdy), 32'd0);
    checkOutput("t5StallFull", 32'(pipeStall), 32'd1);
    nextCycle();
    expectWrite(20, 32'h202);
    @(negedge clk);
    checkOutput("t5LdRdy3", 32'(ldRdy), 32'd1);
    checkOutput("t5Stall3", 32'(pipeStall), 32'd0);
    nextCycle();
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
    expectWrite(11, 32'hA1);
    @(negedge clk);
    checkOutput("t5LdRdy4", 32'(ldRdy), 32'd0);
    nextCycle();
    expectWrite(12, 32'hA2);
    @(negedge clk);
    checkOutput("t5LdRdy5", 32'(ldRdy), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("t5Empty", 32'(ldPending), 32'd0);
    repeat (2) nextCycle();

    $display("[TB] test 6: async reset mid-operation");
    applyStimulus(1, 2'b01, 21, 32'h300, 0, 1, 13, 32'hB0);
    expectWrite(21, 32'h300);
    nextCycle();
    applyStimulus(1, 2'b01, 21, 32'h301, 0, 1, 14, 32'hB1);
    expectWrite(21, 32'h301);
    @(negedge clk);
    checkOutput("t6Stall", 32'(pipeStall), 32'd0);
    nextCycle();
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t6PendingPre", 32'(ldPending), 32'd1);
    checkOutput("t6LdRdyPre",   32'(ldRdy),     32'd0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("t6RstWren",    32'(rfWren),    32'd0);
    checkOutput("t6RstPending", 32'(ldPending), 32'd0);
    checkOutput("t6RstLdRdy",   32'(ldRdy),     32'd1);
    checkOutput("t6RstAddr",    32'(rfRdAddr),  32'd0);
    checkOutput("t6QueueDrained", 32'(expQ.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (4) nextCycle();
    @(negedge clk);
    checkOutput("t6PendingPost", 32'(ldPending), 32'd0);
    checkOutput("t6WrenPost",    32'(rfWren),    32'd0);

    nextCycle();
    checkOutput("endQueueEmpty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
